// File: rtl/vfxp_round_pkg.sv
// Shared encodings and saturation constants for the fixed-point rounding stage.
package vfxp_round_pkg;

    typedef enum logic [1:0] {SEW8 = 2'd0, SEW16 = 2'd1, SEW32 = 2'd2, SEW64 = 2'd3} sew_e;
    typedef enum logic [1:0] {RNU = 2'd0, RNE = 2'd1, RDN = 2'd2, ROD = 2'd3} vxrm_e;

    localparam logic [63:0] SMAX8  = 64'h0000_0000_0000_007F;
    localparam logic [63:0] SMAX16 = 64'h0000_0000_0000_7FFF;
    localparam logic [63:0] SMAX32 = 64'h0000_0000_7FFF_FFFF;
    localparam logic [63:0] SMAX64 = 64'h7FFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] UMAX8  = 64'h0000_0000_0000_00FF;
    localparam logic [63:0] UMAX16 = 64'h0000_0000_0000_FFFF;
    localparam logic [63:0] UMAX32 = 64'h0000_0000_FFFF_FFFF;
    localparam logic [63:0] UMAX64 = 64'hFFFF_FFFF_FFFF_FFFF;

    // Byte offset mask within an element: element bytes - 1.
    function automatic logic [2:0] sew_mask(sew_e sew);
        logic [2:0] m;
        m = 3'd7;
        case (sew)
            SEW8:    m = 3'd0;
            SEW16:   m = 3'd1;
            SEW32:   m = 3'd3;
            default: m = 3'd7;
        endcase
        return m;
    endfunction

    function automatic logic [7:0] smax_byte(sew_e sew, logic [2:0] off);
        logic [63:0] m;
        m = SMAX64;
        case (sew)
            SEW8:    m = SMAX8;
            SEW16:   m = SMAX16;
            SEW32:   m = SMAX32;
            default: m = SMAX64;
        endcase
        return m[{off, 3'b000} +: 8];
    endfunction

    function automatic logic [7:0] umax_byte(sew_e sew, logic [2:0] off);
        logic [63:0] m;
        m = UMAX64;
        case (sew)
            SEW8:    m = UMAX8;
            SEW16:   m = UMAX16;
            SEW32:   m = UMAX32;
            default: m = UMAX64;
        endcase
        return m[{off, 3'b000} +: 8];
    endfunction

endpackage

// File: rtl/fxp_round_lane.sv
// 8-bit lane adder; brk starts a new element and takes the rounding bit as carry-in.
module fxp_round_lane (
    input  logic       brk,
    input  logic       rin,
    input  logic       cin,
    input  logic [7:0] a,
    output logic [7:0] s,
    output logic       cout
);
    logic c0;

    assign c0        = brk ? rin : cin;
    assign {cout, s} = {1'b0, a} + {8'd0, c0};
endmodule

// File: rtl/vfxp_round.sv
// Fixed-point round/saturate stage: stage 1 adds the vxrm increment, stage 2 saturates.
module vfxp_round
    import vfxp_round_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int DW_B       = DATA_WIDTH >> 3,
    parameter int ADDR_WIDTH = 32,
    parameter int SEW_WIDTH  = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    input  logic [DATA_WIDTH-1:0] in_vec,
    input  logic [SEW_WIDTH-1:0]  in_sew,
    input  logic [ADDR_WIDTH-1:0] in_addr,
    input  logic                  in_fxp,
    input  logic                  in_signed,
    input  logic [1:0]            in_vxrm,
    input  logic [DW_B-1:0]       in_vd,
    input  logic [DW_B-1:0]       in_vd1,
    input  logic [DW_B-1:0]       in_vd10,
    input  logic [DW_B-1:0]       in_sat,
    input  logic                  in_vxsat_clr,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_vec,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DW_B-1:0]       out_sat,
    output logic                  out_vxsat
);
    localparam int IW = (DW_B > 1) ? $clog2(DW_B) : 1;

    typedef struct packed {
        logic [DW_B-1:0][7:0]  sum;
        logic [DW_B-1:0]       cout;
        logic [DW_B-1:0]       amsb;
        logic [DW_B-1:0]       sat;
        sew_e                  sew;
        logic                  sgn;
        logic [ADDR_WIDTH-1:0] addr;
    } s1_t;

    sew_e                 sew0;
    vxrm_e                vxrm;
    logic [IW-1:0]        msk0, msk1;
    logic [DW_B-1:0]      st0, r0, amsb0;
    logic [DW_B:0]        carry;
    logic [DW_B-1:0][7:0] sum0, vec2;
    logic [DW_B-1:0]      sat2;
    logic [2:0]           vld_pipe;
    s1_t                  s1;
    logic [IW-1:0]        bi, base, topi, off;
    logic                 ss, su;

    assign sew0        = sew_e'(in_sew);
    assign vxrm        = vxrm_e'(in_vxrm);
    assign msk0        = IW'(sew_mask(sew0));
    assign msk1        = IW'(sew_mask(s1.sew));
    assign carry[0]    = 1'b0;
    assign vld_pipe[0] = in_valid;

    always_comb begin
        r0 = '0;
        for (int b = 0; b < DW_B; b++) begin
            case (vxrm)
                RNU:     r0[b] = in_vd1[b];
                RNE:     r0[b] = in_vd1[b] & (in_vd10[b] | in_vd[b]);
                RDN:     r0[b] = 1'b0;
                default: r0[b] = ~in_vd[b] & (in_vd1[b] | in_vd10[b]);
            endcase
            r0[b] = r0[b] & in_fxp & st0[b];
        end
    end

    for (genvar b = 0; b < DW_B; b++) begin : g_lane
        localparam logic [IW-1:0] BI = IW'(b);
        assign st0[b]   = (BI & msk0) == '0;
        assign amsb0[b] = in_vec[8*b+7];
        fxp_round_lane u_lane (
            .brk  (st0[b]),
            .rin  (r0[b]),
            .cin  (carry[b]),
            .a    (in_vec[8*b +: 8]),
            .s    (sum0[b]),
            .cout (carry[b+1])
        );
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1          <= '0;
            vld_pipe[1] <= 1'b0;
        end else begin
            vld_pipe[1] <= in_valid;
            if (in_valid)
                s1 <= '{sum: sum0, cout: carry[DW_B:1], amsb: amsb0,
                        sat: in_sat & st0 & {DW_B{in_fxp}}, sew: sew0,
                        sgn: in_signed, addr: in_addr};
            else
                s1 <= '0;
        end
    end

    // Overflow is judged at the element's top byte; flags live at its base byte.
    always_comb begin
        vec2 = '0;
        sat2 = '0;
        bi   = '0;
        base = '0;
        topi = '0;
        off  = '0;
        ss   = 1'b0;
        su   = 1'b0;
        for (int b = 0; b < DW_B; b++) begin
            bi      = IW'(b);
            base    = bi & ~msk1;
            topi    = bi | msk1;
            off     = bi & msk1;
            ss      = s1.sat[base] | (s1.sgn & ~s1.amsb[topi] & s1.sum[topi][7]);
            su      = ~s1.sgn & s1.cout[topi];
            vec2[b] = ss ? smax_byte(s1.sew, 3'(off)) :
                      su ? umax_byte(s1.sew, 3'(off)) : s1.sum[b];
            sat2[b] = (bi == base) & (ss | su);
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld_pipe[2] <= 1'b0;
            out_vec     <= '0;
            out_sat     <= '0;
            out_addr    <= '0;
            out_vxsat   <= 1'b0;
        end else begin
            vld_pipe[2] <= vld_pipe[1];
            out_vec     <= vld_pipe[1] ? vec2    : '0;
            out_sat     <= vld_pipe[1] ? sat2    : '0;
            out_addr    <= vld_pipe[1] ? s1.addr : '0;
            // A clear in the same cycle as a saturating result wins.
            out_vxsat   <= in_vxsat_clr ? 1'b0 : (out_vxsat | (out_valid & (|out_sat)));
        end
    end

    assign out_valid = vld_pipe[2];
endmodule

// File: tb/tb_vfxp_round.sv
// Directed-vector bench for vfxp_round with hand-computed expectations.
module tb_vfxp_round;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid, in_fxp, in_signed, in_vxsat_clr;
    logic [63:0] in_vec;
    logic [1:0]  in_sew, in_vxrm;
    logic [31:0] in_addr;
    logic [7:0]  in_vd, in_vd1, in_vd10, in_sat;
    logic        out_valid, out_vxsat;
    logic [63:0] out_vec;
    logic [31:0] out_addr;
    logic [7:0]  out_sat;

    int n_cmp = 0;
    int n_bad = 0;

    vfxp_round dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_vec(in_vec), .in_sew(in_sew),
        .in_addr(in_addr), .in_fxp(in_fxp), .in_signed(in_signed), .in_vxrm(in_vxrm),
        .in_vd(in_vd), .in_vd1(in_vd1), .in_vd10(in_vd10), .in_sat(in_sat),
        .in_vxsat_clr(in_vxsat_clr), .out_valid(out_valid), .out_vec(out_vec),
        .out_addr(out_addr), .out_sat(out_sat), .out_vxsat(out_vxsat)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        in_valid = 0; in_vec = '0; in_sew = '0; in_addr = '0; in_fxp = 0; in_signed = 0;
        in_vxrm = '0; in_vd = '0; in_vd1 = '0; in_vd10 = '0; in_sat = '0; in_vxsat_clr = 0;
    endtask

    task automatic drive(input logic [1:0] sew, input logic [1:0] vxrm, input logic fxp,
                         input logic sgn, input logic [63:0] vec, input logic [7:0] vd,
                         input logic [7:0] vd1, input logic [7:0] vd10, input logic [7:0] sat,
                         input logic [31:0] addr);
        in_valid = 1; in_sew = sew; in_vxrm = vxrm; in_fxp = fxp; in_signed = sgn;
        in_vec = vec; in_vd = vd; in_vd1 = vd1; in_vd10 = vd10; in_sat = sat; in_addr = addr;
    endtask

    // One isolated beat; outputs checked two edges after the capturing edge.
    task automatic xfer(input string tag, input logic [1:0] sew, input logic [1:0] vxrm,
                        input logic sgn, input logic [63:0] vec, input logic [7:0] vd,
                        input logic [7:0] vd1, input logic [7:0] vd10, input logic [7:0] sat,
                        input logic [63:0] ev, input logic [7:0] es);
        drive(sew, vxrm, 1'b1, sgn, vec, vd, vd1, vd10, sat, 32'hC0DE_0040);
        step();
        idle();
        step();
        chk({tag, ".valid"}, 64'(out_valid), 64'd1);
        chk({tag, ".vec"}, out_vec, ev);
        chk({tag, ".sat"}, 64'(out_sat), 64'(es));
        chk({tag, ".addr"}, 64'(out_addr), 64'h0000_0000_C0DE_0040);
    endtask

    task automatic clear_vxsat();
        in_vxsat_clr = 1;
        step();
        in_vxsat_clr = 0;
        chk("vxsat.clr", 64'(out_vxsat), 64'd0);
    endtask

    initial begin
        idle();
        #3;
        chk("rst.valid", 64'(out_valid), 64'd0);
        chk("rst.vec", out_vec, 64'd0);
        chk("rst.sat", 64'(out_sat), 64'd0);
        chk("rst.vxsat", 64'(out_vxsat), 64'd0);
        rst = 1;
        step();

        // sew8 rnu signed: 0x10->0x11, 0x7F saturates, 0xFF(-1)+1 -> 0x00 without saturation
        xfer("rnu8", 2'd0, 2'd0, 1'b1, 64'h0000_0000_00FF_7F10, 8'h00, 8'h07, 8'h00, 8'h00,
             64'h0000_0000_0000_7F11, 8'h02);
        chk("rnu8.vxsat_early", 64'(out_vxsat), 64'd0);
        step();
        chk("rnu8.vxsat", 64'(out_vxsat), 64'd1);

        // fxp=0 back-to-back pass-through with all flags set
        for (int c = 0; c < 5; c++) begin
            if (c < 4)
                drive(2'd0, 2'd0, 1'b0, 1'b1, 64'hDEAD_BEEF_0123_4567, 8'hFF, 8'hFF, 8'hFF,
                      8'hFF, 32'(c));
            else
                idle();
            step();
            if (c >= 1) begin
                chk("pass.valid", 64'(out_valid), 64'd1);
                chk("pass.vec", out_vec, 64'hDEAD_BEEF_0123_4567);
                chk("pass.addr", 64'(out_addr), 64'(c - 1));
                chk("pass.sat", 64'(out_sat), 64'd0);
            end
        end
        step();
        chk("pass.tail", 64'(out_valid), 64'd0);
        chk("pass.vxsat", 64'(out_vxsat), 64'd1);
        clear_vxsat();

        // sew8 rne ties and sticky
        xfer("rne8", 2'd0, 2'd1, 1'b1, 64'h0000_0000_7F10_1110, 8'h02, 8'h07, 8'h04, 8'h00,
             64'h0000_0000_7F11_1210, 8'h00);
        // sew16 rod unsigned; flag bits 1,3,5,7 carry garbage
        xfer("rod16", 2'd1, 2'd3, 1'b0, 64'h00FF_1234_FFFF_FFFE, 8'h86, 8'h60, 8'h2D, 8'h0A,
             64'h0100_1234_FFFF_FFFF, 8'h00);
        step();
        chk("rod16.vxsat", 64'(out_vxsat), 64'd0);

        // sew16 unsigned carry-out saturates, no carry into the next element
        xfer("usat16", 2'd1, 2'd0, 1'b0, 64'h0000_0000_1234_FFFF, 8'h00, 8'h01, 8'h00, 8'h00,
             64'h0000_0000_1234_FFFF, 8'h01);
        step();
        chk("usat16.vxsat", 64'(out_vxsat), 64'd1);
        clear_vxsat();

        xfer("ssat32", 2'd2, 2'd0, 1'b1, 64'h0000_0001_7FFF_FFFF, 8'h00, 8'h01, 8'h00, 8'h00,
             64'h0000_0001_7FFF_FFFF, 8'h01);
        clear_vxsat();
        xfer("rdn32", 2'd2, 2'd2, 1'b1, 64'h7FFF_FFFF_7FFF_FFFF, 8'hFF, 8'hFF, 8'hFF, 8'h00,
             64'h7FFF_FFFF_7FFF_FFFF, 8'h00);
        xfer("usat64", 2'd3, 2'd0, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 8'h00, 8'h01, 8'h00, 8'h00,
             64'hFFFF_FFFF_FFFF_FFFF, 8'h01);
        clear_vxsat();

        // forced saturation; clear coincides with the saturated result on the outputs
        xfer("force64", 2'd3, 2'd2, 1'b1, 64'h8000_0000_0000_0000, 8'h00, 8'h00, 8'h00, 8'h01,
             64'h7FFF_FFFF_FFFF_FFFF, 8'h01);
        in_vxsat_clr = 1;
        step();
        in_vxsat_clr = 0;
        chk("force64.clrwins", 64'(out_vxsat), 64'd0);
        step();
        chk("force64.dropped", 64'(out_vxsat), 64'd0);

        // reset with two beats in flight
        xfer("pre_rst", 2'd0, 2'd0, 1'b1, 64'h0000_0000_0000_007F, 8'h00, 8'h01, 8'h00, 8'h00,
             64'h0000_0000_0000_007F, 8'h01);
        step();
        chk("pre_rst.vxsat", 64'(out_vxsat), 64'd1);
        drive(2'd0, 2'd0, 1'b1, 1'b1, 64'h1111, 8'h00, 8'hFF, 8'h00, 8'h00, 32'h5);
        step();
        drive(2'd0, 2'd0, 1'b1, 1'b1, 64'h2222, 8'h00, 8'hFF, 8'h00, 8'h00, 32'h6);
        #2;
        rst = 0;
        #1;
        chk("midrst.valid", 64'(out_valid), 64'd0);
        chk("midrst.vec", out_vec, 64'd0);
        chk("midrst.addr", 64'(out_addr), 64'd0);
        chk("midrst.vxsat", 64'(out_vxsat), 64'd0);
        idle();
        step();
        rst = 1;
        for (int i = 0; i < 4; i++) begin
            step();
            chk("postrst.valid", 64'(out_valid), 64'd0);
        end
        xfer("recover", 2'd0, 2'd1, 1'b1, 64'h0000_0000_7F10_1110, 8'h02, 8'h07, 8'h04, 8'h00,
             64'h0000_0000_7F11_1210, 8'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule

// File: doc/vfxp_round.md
Name: vfxp_round

Overview:
- Fixed-point rounding and saturation stage that sits directly downstream of the vector multiplier's fixed-point outputs.
- It consumes the per-lane truncated result plus the per-byte rounding flags (LSB, round bit, sticky).
- It applies the vxrm rounding increment, saturates on overflow, and accumulates the sticky vxsat flag.
- Results go to the writeback path with the destination address carried alongside.

Parameters:
- DATA_WIDTH, 64, vector datapath width in bits.
- DW_B, DATA_WIDTH>>3, number of byte lanes (flag-vector width).
- ADDR_WIDTH, 32, destination address width.
- SEW_WIDTH, 2, element-width encoding: 0=8b, 1=16b, 2=32b, 3=64b.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-low reset.
- in_valid  in  1  input beat valid. No backpressure.
- in_vec  in  DATA_WIDTH  truncated (shifted) results, packed per in_sew.
- in_sew  in  SEW_WIDTH  element width.
- in_addr  in  ADDR_WIDTH  destination address.
- in_fxp  in  1  1 = apply rounding/saturation; 0 = pass in_vec through unchanged.
- in_signed  in  1  1 = signed saturation bounds; 0 = unsigned bounds.
- in_vxrm  in  2  rounding mode: 0=rnu, 1=rne, 2=rdn, 3=rod.
- in_vd  in  DW_B  per-element result LSB v[d].
- in_vd1  in  DW_B  per-element round bit v[d-1].
- in_vd10  in  DW_B  per-element sticky OR of v[d-2:0] (excludes the round bit).
- in_sat  in  DW_B  per-element forced saturation to positive max (upstream -1*-1 case).
- in_vxsat_clr  in  1  clear the sticky vxsat flag.
- out_valid  out  1  result valid.
- out_vec  out  DATA_WIDTH  rounded/saturated result.
- out_addr  out  ADDR_WIDTH  delayed in_addr.
- out_sat  out  DW_B  per-element "this element saturated" flag.
- out_vxsat  out  1  sticky OR of all saturation events since the last clear/reset.

Behaviour:
- Reset (rst=0, async): all pipeline registers and all outputs go to 0, including out_vxsat. A reset mid-operation discards in-flight beats; no out_valid follows.
- Latency is fixed at 2 cycles: in_valid at edge N gives out_valid at edge N+2. Throughput is 1 beat/cycle with no bubbles.
- Invalid beats zero all data/flag registers.
- Element i flags sit at byte index i*(SEW/8): sew16 uses bits 0,2,4,6; sew32 uses 0,4; sew64 uses 0. All other flag bits are ignored on input and driven 0 on out_sat.
- Rounding increment r per element:
  - rnu: r = vd1.
  - rne: r = vd1 & (vd10 | vd).
  - rdn: r = 0.
  - rod: r = ~vd & (vd1 | vd10).
- Stage 1: register the element-wise sum in_vec_elem + r, computed one bit wider per element. Also register in_sat, sew, signed, fxp and addr.
- Stage 2, saturation:
  - Signed: overflow when the operand equals signed max and r=1. The result becomes signed max (0x7F / 0x7FFF / 0x7FFF_FFFF / 0x7FFF_FFFF_FFFF_FFFF).
  - Unsigned: overflow on carry-out; the result becomes all-ones.
  - in_sat=1 forces signed max regardless of r.
  - Each saturated element sets its out_sat bit.
- in_fxp=0: out_vec = in_vec, out_sat = 0, and vxsat is unaffected.
- vxsat register:
  - next = in_vxsat_clr ? 0 : (vxsat | (out_valid_next & |out_sat_next)).
  - If a clear coincides with a saturating beat leaving stage 2, the clear wins; the event is dropped and software re-reads per instruction.
- out_vxsat changes one cycle after the event.
- No carry crosses element boundaries at any SEW. A 64-bit element uses the full 65-bit add.

Decomposition:
- Shared package: SEW encodings (SEW8..SEW64), VXRM encodings (RNU/RNE/RDN/ROD), and per-SEW signed-max/unsigned-max constants.
- One natural sub-module, fxp_round_lane: a combinational 8-bit lane adder with carry-in/carry-out and a chain-break control. Eight instances chained per SEW form the element adders.

Test Plan:
- sew=0, vxrm=rnu, fxp=1, signed=1: lane0=0x10 with vd1=1 → 0x11. lane1=0x7F with vd1=1 → 0x7F, out_sat[1]=1, out_vxsat=1 one cycle after out_valid.
- sew=0, vxrm=rne: 0x10 (vd=0, vd1=1, vd10=0) → 0x10. 0x11 (vd=1, vd1=1, vd10=0) → 0x12. 0x10 (vd1=1, vd10=1) → 0x11.
- sew=1, vxrm=rod, unsigned: 0xFFFE (vd=0, vd10=1) → 0xFFFF. 0xFFFF with vd=1 → 0xFFFF, no saturation. Flags at bits 1,3,5,7 are ignored.
- sew=3, signed, in_sat[0]=1, in_vec=0x8000_0000_0000_0000 → out_vec=0x7FFF_FFFF_FFFF_FFFF, out_sat=0x01. in_vxsat_clr in the same cycle the saturated beat leaves stage 2 → out_vxsat stays 0.
- Back-to-back 4 beats with fxp=0, in_vec=0xDEAD_BEEF_0123_4567 and addr 0..3 → identical out_vec and matching out_addr 2 cycles later, out_sat=0, vxsat unchanged.
- Drive rst low while 2 beats are in flight → outputs go to 0 immediately; after release no out_valid appears until a new in_valid.
